// File: rtl/pic_cascade_if.sv
// rtl/pic_cascade_if.sv - cascade controller bus: INTA, config, cascade ID and vector-drive signals
interface pic_cascade_if #(
  parameter int ID_W = 3
);
  localparam int N_IR = 2 ** ID_W;

  logic            inta_n;
  logic            sngl;
  logic            sp;
  logic            mode_86;
  logic [N_IR-1:0] slave_mask;
  logic [ID_W-1:0] slave_id;
  logic [ID_W-1:0] irq_id;
  logic [ID_W-1:0] casc_in;
  logic [ID_W-1:0] casc_out;
  logic            casc_oe;
  logic            vec_en;
  logic [1:0]      vec_sel;
  logic            ack_first;
  logic            seq_done;
  logic            seq_abort;
  logic            busy;

  modport master (
    output inta_n, sngl, sp, mode_86, slave_mask, slave_id, irq_id, casc_in,
    input  casc_out, casc_oe, vec_en, vec_sel, ack_first, seq_done, seq_abort, busy
  );

  modport slave (
    input  inta_n, sngl, sp, mode_86, slave_mask, slave_id, irq_id, casc_in,
    output casc_out, casc_oe, vec_en, vec_sel, ack_first, seq_done, seq_abort, busy
  );
endinterface

// File: rtl/pic_cascade_ctrl.sv
// rtl/pic_cascade_ctrl.sv - PIC INTA sequence tracker with cascade ID drive/decode and abort timeout
module pic_cascade_ctrl #(
  parameter int ID_W          = 3,
  parameter int TMO_CYC       = 255,
  parameter int CALL_PULSE_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  pic_cascade_if.slave bus
);
  localparam int            TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            inta_q;
  logic [1:0]      count;
  logic [TW-1:0]   timer;
  logic            sngl_l, sp_l, mode_l, sbit_l, match_q;
  logic [ID_W-1:0] irq_l, sid_l;

  logic            fall, rise, start, next_pulse, done_ev, tmo_ev, end_ev;
  logic            sngl_e, sp_e, mode_e, sbit_e, match_e, own;
  logic [ID_W-1:0] irq_e, sid_e;
  logic [1:0]      np, sel;

  logic            busy_d, casc_oe_d, vec_en_d;
  logic [ID_W-1:0] casc_out_d;
  logic [1:0]      vec_sel_d;

  assign fall       = inta_q & ~bus.inta_n;
  assign rise       = ~inta_q & bus.inta_n;
  // The seq_done cycle swallows any fall so back-to-back sequences need a fresh edge.
  assign start      = (state == S_IDLE) & fall & ~bus.seq_done;
  assign next_pulse = (state == S_HIGH) & fall;
  assign done_ev    = (state == S_LOW) & rise & (count == (mode_l ? 2'd2 : 2'd3));
  assign tmo_ev     = (state == S_HIGH) & ~fall & (timer == TMO_LAST);
  assign end_ev     = done_ev | tmo_ev;

  // On the opening fall the live config is used; afterwards only the latched copy.
  assign sngl_e  = start ? bus.sngl : sngl_l;
  assign sp_e    = start ? bus.sp : sp_l;
  assign mode_e  = start ? bus.mode_86 : mode_l;
  assign sbit_e  = start ? bus.slave_mask[bus.irq_id] : sbit_l;
  assign irq_e   = start ? bus.irq_id : irq_l;
  assign sid_e   = start ? bus.slave_id : sid_l;
  assign np      = start ? 2'd1 : count + 2'd1;
  assign match_e = (np == 2'd2) ? (bus.casc_in == sid_e) : match_q;
  assign sel     = (np == 2'd1) ? 2'd0 : np - 2'd1;

  always_comb begin
    own = 1'b0;
    if (np == 2'd1) begin
      own = (CALL_PULSE_EN != 0) && !mode_e && (sngl_e || sp_e);
    end else if (sngl_e) begin
      own = 1'b1;
    end else if (sp_e) begin
      own = !sbit_e;
    end else begin
      own = match_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOW;
      S_LOW: begin
        if (rise) state_nx = done_ev ? S_IDLE : S_HIGH;
      end
      S_HIGH: begin
        if (fall) state_nx = S_LOW;
        else if (tmo_ev) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = bus.busy;
    casc_oe_d = bus.casc_oe;
    vec_en_d  = bus.vec_en;
    vec_sel_d = bus.vec_sel;
    if (start) begin
      busy_d    = 1'b1;
      casc_oe_d = sp_e & ~sngl_e & sbit_e;
    end else if (end_ev) begin
      busy_d    = 1'b0;
      casc_oe_d = 1'b0;
    end
    if (start || next_pulse) begin
      vec_en_d  = own;
      vec_sel_d = own ? sel : 2'd0;
    end else if ((state == S_LOW) && rise) begin
      vec_en_d  = 1'b0;
      vec_sel_d = 2'd0;
    end
    casc_out_d = casc_oe_d ? irq_e : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_q  <= 1'b1;
      count   <= 2'd0;
      timer   <= '0;
      match_q <= 1'b0;
      sngl_l  <= 1'b0;
      sp_l    <= 1'b0;
      mode_l  <= 1'b0;
      sbit_l  <= 1'b0;
      irq_l   <= '0;
      sid_l   <= '0;
    end else begin
      inta_q <= bus.inta_n;
      if (start) begin
        sngl_l  <= bus.sngl;
        sp_l    <= bus.sp;
        mode_l  <= bus.mode_86;
        sbit_l  <= bus.slave_mask[bus.irq_id];
        irq_l   <= bus.irq_id;
        sid_l   <= bus.slave_id;
        count   <= 2'd1;
        match_q <= 1'b0;
      end else if (next_pulse) begin
        count <= np;
        if ((np == 2'd2) && !sngl_l && !sp_l) match_q <= match_e;
      end else if (state == S_IDLE) begin
        count   <= 2'd0;
        match_q <= 1'b0;
      end
      if ((state == S_LOW) && rise) begin
        timer <= '0;
      end else if ((state == S_HIGH) && !fall) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack_first <= 1'b0;
      bus.seq_done  <= 1'b0;
      bus.seq_abort <= 1'b0;
      bus.busy      <= 1'b0;
      bus.casc_oe   <= 1'b0;
      bus.casc_out  <= '0;
      bus.vec_en    <= 1'b0;
      bus.vec_sel   <= 2'd0;
    end else begin
      bus.ack_first <= start;
      bus.seq_done  <= done_ev;
      bus.seq_abort <= tmo_ev;
      bus.busy      <= busy_d;
      bus.casc_oe   <= casc_oe_d;
      bus.casc_out  <= casc_out_d;
      bus.vec_en    <= vec_en_d;
      bus.vec_sel   <= vec_sel_d;
    end
  end
endmodule

// File: tb/tb_pic_cascade_ctrl.sv
// tb/tb_pic_cascade_ctrl.sv - directed and randomized INTA sequences against a sequence-level model
module tb_pic_cascade_ctrl;
  localparam int ID_W = 3;
  localparam int TMO  = 8;
  localparam int CALL = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic_cascade_if #(.ID_W(ID_W)) bus ();

  pic_cascade_ctrl #(.ID_W(ID_W), .TMO_CYC(TMO), .CALL_PULSE_EN(CALL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sequence-level model: whether a sequence is open, which pulse, and the gap length.
  bit       m_prev, m_active, m_low, m_done, m_ack, m_abort, m_vec, m_match;
  bit       m_sngl, m_sp, m_86, m_sbit;
  int       m_n, m_gap, m_sel, m_irq, m_sid;

  function automatic bit model_owns(input int n);
    if (n == 1) return (CALL != 0) && !m_86 && (m_sngl || m_sp);
    if (m_sngl) return 1'b1;
    if (m_sp) return !m_sbit;
    return m_match;
  endfunction

  task automatic model_reset();
    m_prev = 1; m_active = 0; m_low = 0; m_done = 0; m_ack = 0; m_abort = 0;
    m_vec = 0; m_match = 0; m_n = 0; m_gap = 0; m_sel = 0;
  endtask

  task automatic model_open_pulse();
    m_vec = model_owns(m_n);
    m_sel = m_vec ? ((m_n == 1) ? 0 : m_n - 1) : 0;
  endtask

  task automatic model_step();
    bit fall, rise, done_was;
    fall     = m_prev && !bus.inta_n;
    rise     = !m_prev && bus.inta_n;
    done_was = m_done;
    m_ack = 0; m_done = 0; m_abort = 0;
    if (!m_active) begin
      if (fall && !done_was) begin
        m_sngl = bus.sngl; m_sp = bus.sp; m_86 = bus.mode_86;
        m_sbit = bus.slave_mask[bus.irq_id]; m_irq = bus.irq_id; m_sid = bus.slave_id;
        m_active = 1; m_low = 1; m_n = 1; m_ack = 1; m_match = 0;
        model_open_pulse();
      end
    end else if (m_low) begin
      if (rise) begin
        m_vec = 0; m_sel = 0;
        if (m_n == (m_86 ? 2 : 3)) begin
          m_done = 1; m_active = 0;
        end else begin
          m_low = 0; m_gap = 0;
        end
      end
    end else begin
      if (fall) begin
        m_n++; m_low = 1;
        if (m_n == 2) m_match = (int'(bus.casc_in) == m_sid);
        model_open_pulse();
      end else if (m_gap == TMO - 1) begin
        m_abort = 1; m_active = 0;
      end else begin
        m_gap++;
      end
    end
    m_prev = bus.inta_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor used by the directed tests to pin the model with literal expectations.
  int cur_pulse = 0;
  int mon_ack, mon_done, mon_abort, mon_oe, mon_out;
  int mon_vec[1:4];
  int mon_sel[1:4];

  task automatic clear_mon();
    mon_ack = 0; mon_done = 0; mon_abort = 0; mon_oe = 0; mon_out = 0;
    for (int i = 1; i <= 4; i++) begin
      mon_vec[i] = 0; mon_sel[i] = 0;
    end
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      chk("busy", bus.busy, m_active);
      chk("casc_oe", bus.casc_oe, m_active && m_sbit && m_sp && !m_sngl);
      chk("casc_out", bus.casc_out, (m_active && m_sbit && m_sp && !m_sngl) ? m_irq : 0);
      chk("vec_en", bus.vec_en, m_vec);
      chk("vec_sel", bus.vec_sel, m_sel);
      chk("ack_first", bus.ack_first, m_ack);
      chk("seq_done", bus.seq_done, m_done);
      chk("seq_abort", bus.seq_abort, m_abort);
      if (bus.ack_first) mon_ack++;
      if (bus.seq_done) mon_done++;
      if (bus.seq_abort) mon_abort++;
      if (bus.casc_oe) begin
        mon_oe++;
        mon_out = bus.casc_out;
      end
      if (bus.vec_en && cur_pulse >= 1 && cur_pulse <= 4) begin
        mon_vec[cur_pulse] = 1;
        mon_sel[cur_pulse] = bus.vec_sel;
      end
    end
  end

  task automatic pulse(input int p, input int lo, input int hi);
    @(negedge clk);
    bus.inta_n = 1'b0;
    cur_pulse  = p;
    repeat (lo) @(negedge clk);
    bus.inta_n = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic set_cfg(input bit sngl, input bit sp, input bit m86, input int mask,
                         input int irq, input int sid, input int cin);
    bus.sngl       = sngl;
    bus.sp         = sp;
    bus.mode_86    = m86;
    bus.slave_mask = 8'(mask);
    bus.irq_id     = 3'(irq);
    bus.slave_id   = 3'(sid);
    bus.casc_in    = 3'(cin);
  endtask

  task automatic rand_cfg();
    bus.sngl       = ($urandom_range(0, 3) == 0);
    bus.sp         = 1'($urandom);
    bus.mode_86    = 1'($urandom);
    bus.slave_mask = 8'($urandom);
    bus.irq_id     = 3'($urandom);
    bus.slave_id   = 3'($urandom);
    bus.casc_in    = $urandom_range(0, 1) ? bus.slave_id : 3'($urandom);
  endtask

  initial begin
    bus.inta_n = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_casc_oe", bus.casc_oe, 0);
    chk("rst_vec_en", bus.vec_en, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single, 8086
    set_cfg(1, 1, 1, 0, 0, 0, 0);
    clear_mon();
    pulse(1, 3, 3);
    pulse(2, 3, 3);
    chk("t1_ack", mon_ack, 1);
    chk("t1_vec1", mon_vec[1], 0);
    chk("t1_vec2", mon_vec[2], 1);
    chk("t1_sel2", mon_sel[2], 1);
    chk("t1_done", mon_done, 1);
    chk("t1_oe", mon_oe, 0);

    // master 8080 with slave on IR2; live config changes after latch must not matter
    set_cfg(0, 1, 0, 'h04, 2, 0, 0);
    clear_mon();
    pulse(1, 3, 3);
    bus.irq_id = 3'd6;
    bus.slave_mask = 8'h00;
    pulse(2, 3, 3);
    pulse(3, 3, 3);
    chk("t2_oe_cycles", mon_oe, 17);
    chk("t2_out", mon_out, 2);
    chk("t2_vec1", mon_vec[1], 1);
    chk("t2_sel1", mon_sel[1], 0);
    chk("t2_vec2", mon_vec[2], 0);
    chk("t2_vec3", mon_vec[3], 0);
    chk("t2_done", mon_done, 1);

    // master 8086, IR5 has no slave
    set_cfg(0, 1, 1, 'h04, 5, 0, 0);
    clear_mon();
    pulse(1, 3, 3);
    pulse(2, 3, 3);
    chk("t3_oe", mon_oe, 0);
    chk("t3_vec1", mon_vec[1], 0);
    chk("t3_vec2", mon_vec[2], 1);
    chk("t3_sel2", mon_sel[2], 1);

    // slave 8080, id 3: matching then non-matching cascade bus
    for (int k = 0; k < 2; k++) begin
      set_cfg(0, 0, 0, 0, 0, 3, (k == 0) ? 3 : 4);
      clear_mon();
      pulse(1, 3, 3);
      pulse(2, 3, 3);
      pulse(3, 3, 3);
      chk("t4_vec1", mon_vec[1], 0);
      chk("t4_vec2", mon_vec[2], (k == 0) ? 1 : 0);
      chk("t4_vec3", mon_vec[3], (k == 0) ? 1 : 0);
      chk("t4_sel3", mon_sel[3], (k == 0) ? 2 : 0);
      chk("t4_done", mon_done, 1);
    end

    // timeout with cascaded master, then a fresh sequence
    set_cfg(0, 1, 0, 'h04, 2, 0, 0);
    clear_mon();
    pulse(1, 3, 12);
    chk("t5_abort", mon_abort, 1);
    chk("t5_done", mon_done, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_oe", bus.casc_oe, 0);
    clear_mon();
    pulse(1, 3, 3);
    pulse(2, 3, 3);
    pulse(3, 3, 3);
    chk("t5_reack", mon_ack, 1);
    chk("t5_redone", mon_done, 1);

    // async reset in the middle of pulse 2
    set_cfg(0, 1, 1, 'h04, 2, 0, 0);
    clear_mon();
    pulse(1, 3, 3);
    @(negedge clk);
    bus.inta_n = 1'b0;
    cur_pulse  = 2;
    repeat (2) @(negedge clk);
    chk("t6_busy_pre", bus.busy, 1);
    chk("t6_oe_pre", bus.casc_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", bus.busy, 0);
    chk("t6_oe_rst", bus.casc_oe, 0);
    chk("t6_out_rst", bus.casc_out, 0);
    chk("t6_vec_rst", bus.vec_en, 0);
    repeat (2) @(negedge clk);
    bus.inta_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_done", mon_done, 0);
    chk("t6_idle", bus.busy, 0);

    // randomized sequences, including zero-length gaps, timeouts and stray resets
    for (int s = 0; s < 300; s++) begin
      int npl;
      rand_cfg();
      npl = $urandom_range(1, 4);
      for (int p = 1; p <= npl; p++) begin
        if (p > 1 && $urandom_range(0, 1) == 1) rand_cfg();
        if ($urandom_range(0, 59) == 0) begin
          @(negedge clk);
          bus.inta_n = 1'b0;
          #1 rst_n = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          if ($urandom_range(0, 1) == 1) bus.inta_n = 1'b1;
          rst_n = 1'b1;
        end else begin
          pulse(p, $urandom_range(1, 4), $urandom_range(0, 11));
        end
      end
      bus.inta_n = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pic_cascade_ctrl.md
Name: pic_cascade_ctrl

Overview:
Clocked, parametrised cascade controller for the PIC interrupt-acknowledge sequence. It tracks INTA pulses in 8086 (2-pulse) or 8080 (3-pulse) mode. As master, it drives the cascade ID bus. As slave, it decodes that bus and decides whether this device drives each vector byte. It sits between the priority resolver/ISR logic and the data-bus driver, and adds an abort timeout and clean sequence framing.

Parameters:
ID_W, 3, cascade bus width; N_IR = 2**ID_W interrupt inputs
TMO_CYC, 255, max clk cycles allowed between INTA pulses before the sequence is aborted (min 1)
CALL_PULSE_EN, 1, 1 = master drives pulse 1 in 8080 mode (CALL opcode)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inta_n  in  1  interrupt acknowledge, active low, synchronous to clk
sngl  in  1  single mode (ICW1); 1 = no cascading
sp  in  1  1 = master, 0 = slave
mode_86  in  1  1 = 8086 (2 pulses), 0 = 8080 (3 pulses)
slave_mask  in  N_IR  master only: bit i set = slave attached on IR i (ICW3)
slave_id  in  ID_W  slave only: own cascade ID (ICW3)
irq_id  in  ID_W  master only: IR being acknowledged
casc_in  in  ID_W  cascade bus, input side
casc_out  out  ID_W  cascade bus, drive value
casc_oe  out  1  cascade bus output enable
vec_en  out  1  this device drives the data bus this pulse
vec_sel  out  2  byte select: 0 = CALL opcode, 1 = vector / low address, 2 = high address
ack_first  out  1  one-cycle strobe on first INTA pulse (freezes resolver, sets ISR)
seq_done  out  1  one-cycle strobe on completion
seq_abort  out  1  one-cycle strobe on timeout abort
busy  out  1  sequence in progress

Behaviour:
- Reset (async, rst_n=0): all outputs 0, casc_out=0, state IDLE, pulse count 0, inta_q=1, timer 0.
- Edge detect: inta_q registered. fall = inta_q & ~inta_n. rise = ~inta_q & inta_n.
- States: IDLE, LOW (pulse active), HIGH (between pulses).
- IDLE, on fall:
  - latch sngl, sp, mode_86, irq_id, slave_mask[irq_id], slave_id
  - pulse count = 1; ack_first=1 for one cycle; busy=1; go LOW
- Config inputs are ignored for the rest of the sequence; only latched values are used.
- Last pulse index: 2 if mode_86 latched, else 3.
- LOW, on rise:
  - if count == last: seq_done=1 for one cycle, go IDLE
  - else go HIGH, clear timer
- HIGH: timer increments each cycle.
  - on fall: count += 1, go LOW
  - if timer reaches TMO_CYC-1 without a fall: seq_abort=1 for one cycle, go IDLE
- A fall in the same cycle as the timeout wins; no abort occurs.
- casc_oe / casc_out:
  - asserted only when latched sp=1, sngl=0 and slave bit=1
  - casc_oe=1, casc_out=irq_id from the cycle after the first fall until the cycle the sequence ends (done or abort)
  - 0 otherwise
- Slave match: when sp=0 and sngl=0, on the fall of pulse 2, match <= (casc_in == latched slave_id). Cleared in IDLE.
- vec_en is registered: 1 from the cycle after a fall to the cycle after the following rise, when this device owns the pulse:
  - pulse 1, 8080 mode, CALL_PULSE_EN=1: master or single owns it (vec_sel=0). Slave never owns pulse 1.
  - pulse 1, 8086 mode: nobody drives.
  - pulses 2..last, master with no slave on irq_id, or single: owns them.
  - pulses 2..last, slave: owns them only if match=1.
  - pulses 2..last, master with slave attached: vec_en=0.
  - vec_sel = count-1 during pulses 2..3; vec_sel=0 on pulse 1.
- busy=1 from the cycle after the first fall until the cycle of seq_done/seq_abort.
- A fall arriving in the same cycle as seq_done starts no new sequence. The next sequence needs a fresh fall seen from IDLE.
- Reset mid-sequence: everything returns to reset values immediately; no done/abort strobe is emitted.

Test Plan:
- Single, 8086: two INTA pulses -> ack_first once; vec_en=0 on pulse 1; vec_en=1, vec_sel=1 on pulse 2; seq_done after the 2nd rise; casc_oe stays 0.
- Master, 8080, slave_mask=8'h04, irq_id=2 -> casc_oe=1, casc_out=3'd2 across all 3 pulses; vec_en=1 only on pulse 1 (vec_sel=0); seq_done after the 3rd rise.
- Master, 8086, slave_mask=8'h04, irq_id=5 (no slave) -> casc_oe=0; vec_en=1, vec_sel=1 on pulse 2.
- Slave, 8080, slave_id=3: casc_in=3 -> vec_en on pulses 2 and 3 with vec_sel 1 then 2. Repeat with casc_in=4 -> vec_en stays 0.
- Timeout, TMO_CYC=8: one pulse, then inta_n held high for 8 cycles -> seq_abort pulse, busy=0, casc_oe=0. A following fall starts a new sequence with ack_first.
- Reset asserted mid pulse 2 (master cascaded) -> casc_oe, vec_en and busy drop immediately; no seq_done; idle after release.
